// File: rtl/mux_rr_arb_if.sv
// Valid/ready bundle for the N-to-1 round-robin arbitrated mux.
// slave is the arbiter's view; master is the view of whatever drives and drains it.
interface mux_rr_arb_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int CH_W   = 2
);
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_last;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_last;
  logic [CH_W-1:0]          out_ch;
  logic                     out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last,
    output out_ch,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  out_ch,
    output out_ready
  );
endinterface

// File: rtl/mux_rr_arb.sv
// N-to-1 round-robin arbitrated mux with optional packet lock and a registered output beat.
// Grant is combinational from the pointer/lock state; the output stage is a single skid-free register.
module mux_rr_arb #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int CH_W   = 2,
  parameter int LOCK   = 1
) (
  input  logic        clk,
  input  logic        rst,
  mux_rr_arb_if.slave bus
);

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   lock_ch_q, lock_ch_d;

  logic [CH_W-1:0]   rr_idx;
  logic              rr_found;
  logic [CH_W-1:0]   grant;
  logic              grant_en;
  logic [DATA_W-1:0] grant_data;
  logic              grant_last;
  logic [NUM_CH-1:0] ready;
  logic              can_load;
  logic              accept;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;
  logic [CH_W-1:0]   out_ch_q;

  assign can_load = !out_valid_q || bus.out_ready;

  // Two priority scans: the later loop wins, so the lowest valid index at or
  // above ptr beats anything below it, which gives the modular scan order
  // without a modulo, so non-power-of-2 channel counts wrap correctly.
  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.in_valid[i] && (i < int'(ptr_q))) begin
        rr_found = 1'b1;
        rr_idx   = CH_W'(i);
      end
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.in_valid[i] && (i >= int'(ptr_q))) begin
        rr_found = 1'b1;
        rr_idx   = CH_W'(i);
      end
    end
  end

  // A locked channel keeps its grant even while idle, so other channels stall.
  always_comb begin
    if (state_q == ST_LOCKED) begin
      grant    = lock_ch_q;
      grant_en = 1'b1;
    end else begin
      grant    = rr_idx;
      grant_en = rr_found;
    end
  end

  always_comb begin
    ready      = '0;
    grant_data = '0;
    grant_last = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == CH_W'(i)) begin
        grant_data = bus.in_data[i*DATA_W +: DATA_W];
        grant_last = bus.in_last[i];
        if (!rst && can_load && grant_en)
          ready[i] = (state_q == ST_LOCKED) ? 1'b1 : bus.in_valid[i];
      end
    end
  end

  assign bus.in_ready = ready;
  assign accept       = |(bus.in_valid & ready);

  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    ptr_d     = ptr_q;
    if (accept) begin
      if (state_q == ST_ARB) begin
        if ((LOCK != 0) && !grant_last) begin
          state_d   = ST_LOCKED;
          lock_ch_d = grant;
        end
      end else if (grant_last) begin
        state_d = ST_ARB;
      end
      // The pointer only moves once arbitration for a packet (or beat) is over.
      if ((LOCK == 0) || grant_last)
        ptr_d = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ARB;
      ptr_q     <= '0;
      lock_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lock_ch_q <= lock_ch_d;
    end
  end

  // NOTE: the data/ch/last fields are reset too, so a freshly reset output
  // shows a defined all-zero beat rather than leftover payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= grant_data;
      out_last_q  <= grant_last;
      out_ch_q    <= grant;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
// Directed bench for mux_rr_arb: three instances cover LOCK=0, LOCK=1 and a 3-channel wrap.
// Inputs change and outputs are sampled on the falling edge; the DUT updates on the rising edge.
module tb_mux_rr_arb;
  logic clk = 1'b0;
  logic rst0, rst1, rst2;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  mux_rr_arb_if #(.NUM_CH(4), .DATA_W(8), .CH_W(2)) b0 ();
  mux_rr_arb_if #(.NUM_CH(4), .DATA_W(8), .CH_W(2)) b1 ();
  mux_rr_arb_if #(.NUM_CH(3), .DATA_W(8), .CH_W(2)) b2 ();

  mux_rr_arb #(.NUM_CH(4), .DATA_W(8), .CH_W(2), .LOCK(0)) u_rr (.clk(clk), .rst(rst0), .bus(b0));
  mux_rr_arb #(.NUM_CH(4), .DATA_W(8), .CH_W(2), .LOCK(1)) u_lk (.clk(clk), .rst(rst1), .bus(b1));
  mux_rr_arb #(.NUM_CH(3), .DATA_W(8), .CH_W(2), .LOCK(0)) u_n3 (.clk(clk), .rst(rst2), .bus(b2));

  // Output beat packed as {valid, last, ch, data}.
  function automatic logic [11:0] out0();
    return {b0.out_valid, b0.out_last, b0.out_ch, b0.out_data};
  endfunction
  function automatic logic [11:0] out1();
    return {b1.out_valid, b1.out_last, b1.out_ch, b1.out_data};
  endfunction
  function automatic logic [11:0] out2();
    return {b2.out_valid, b2.out_last, b2.out_ch, b2.out_data};
  endfunction

  task automatic test_reset();
    rst0 = 1'b1;
    b0.in_valid = 4'b1111;
    b0.in_last  = 4'b1111;
    b0.in_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    b0.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (b0.in_ready !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_in_ready: got %b expected 0000", b0.in_ready);
    end
    tests_run++;
    if (out0() !== 12'h000) begin
      tests_failed++; $display("FAIL reset_out: got %h expected 000", out0());
    end
    rst0 = 1'b0; #1;
    tests_run++;
    if (b0.in_ready !== 4'b0001) begin
      tests_failed++; $display("FAIL first_grant: got %b expected 0001", b0.in_ready);
    end
    @(negedge clk);
    tests_run++;
    if (out0() !== {1'b1, 1'b1, 2'd0, 8'hA0}) begin
      tests_failed++; $display("FAIL first_out: got %h expected %h", out0(), {1'b1, 1'b1, 2'd0, 8'hA0});
    end
  endtask

  task automatic test_round_robin();
    logic [11:0] exp;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      exp = {1'b1, 1'b1, 2'(k % 4), 8'(8'hA0 + k % 4)};
      tests_run++;
      if (out0() !== exp) begin
        tests_failed++; $display("FAIL rr_beat%0d: got %h expected %h", k, out0(), exp);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] exp;
    b0.out_ready = 1'b0; #1;
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (b0.in_ready !== 4'b0000) begin
        tests_failed++; $display("FAIL bp_ready%0d: got %b expected 0000", k, b0.in_ready);
      end
      @(negedge clk);
      tests_run++;
      if (out0() !== {1'b1, 1'b1, 2'd1, 8'hA1}) begin
        tests_failed++; $display("FAIL bp_hold%0d: got %h expected %h", k, out0(), {1'b1, 1'b1, 2'd1, 8'hA1});
      end
    end
    b0.out_ready = 1'b1;
    for (int k = 2; k <= 3; k++) begin
      @(negedge clk);
      exp = {1'b1, 1'b1, 2'(k), 8'(8'hA0 + k)};
      tests_run++;
      if (out0() !== exp) begin
        tests_failed++; $display("FAIL bp_resume%0d: got %h expected %h", k, out0(), exp);
      end
    end
    b0.in_valid = 4'b0000;
  endtask

  task automatic test_lock();
    @(negedge clk);
    rst1 = 1'b0;
    b1.in_valid = 4'b0100; b1.in_last = 4'b0000; b1.in_data[16 +: 8] = 8'hB1; #1;
    tests_run++;
    if (b1.in_ready !== 4'b0100) begin
      tests_failed++; $display("FAIL lock_rdy0: got %b expected 0100", b1.in_ready);
    end
    @(negedge clk);
    tests_run++;
    if (out1() !== {1'b1, 1'b0, 2'd2, 8'hB1}) begin
      tests_failed++; $display("FAIL lock_beat1: got %h expected %h", out1(), {1'b1, 1'b0, 2'd2, 8'hB1});
    end
    b1.in_valid = 4'b1101; b1.in_last = 4'b1001;
    b1.in_data  = {8'hC3, 8'hB2, 8'h00, 8'hC0}; #1;
    tests_run++;
    if (b1.in_ready !== 4'b0100) begin
      tests_failed++; $display("FAIL lock_rdy1: got %b expected 0100", b1.in_ready);
    end
    @(negedge clk);
    tests_run++;
    if (out1() !== {1'b1, 1'b0, 2'd2, 8'hB2}) begin
      tests_failed++; $display("FAIL lock_beat2: got %h expected %h", out1(), {1'b1, 1'b0, 2'd2, 8'hB2});
    end
    b1.in_valid = 4'b1001;
    for (int k = 0; k < 2; k++) begin
      #1;
      tests_run++;
      if (b1.in_ready !== 4'b0100) begin
        tests_failed++; $display("FAIL lock_stall%0d: got %b expected 0100", k, b1.in_ready);
      end
      @(negedge clk);
      tests_run++;
      if (b1.out_valid !== 1'b0) begin
        tests_failed++; $display("FAIL lock_idle%0d: got %b expected 0", k, b1.out_valid);
      end
    end
    b1.in_valid = 4'b1101; b1.in_last = 4'b1101; b1.in_data[16 +: 8] = 8'hB3; #1;
    tests_run++;
    if (b1.in_ready !== 4'b0100) begin
      tests_failed++; $display("FAIL lock_rdy3: got %b expected 0100", b1.in_ready);
    end
    @(negedge clk);
    tests_run++;
    if (out1() !== {1'b1, 1'b1, 2'd2, 8'hB3}) begin
      tests_failed++; $display("FAIL lock_beat3: got %h expected %h", out1(), {1'b1, 1'b1, 2'd2, 8'hB3});
    end
    b1.in_valid = 4'b1001; #1;
    tests_run++;
    if (b1.in_ready !== 4'b1000) begin
      tests_failed++; $display("FAIL lock_next_ch3: got %b expected 1000", b1.in_ready);
    end
    @(negedge clk);
    tests_run++;
    if (out1() !== {1'b1, 1'b1, 2'd3, 8'hC3}) begin
      tests_failed++; $display("FAIL lock_out_ch3: got %h expected %h", out1(), {1'b1, 1'b1, 2'd3, 8'hC3});
    end
    b1.in_valid = 4'b0001; #1;
    tests_run++;
    if (b1.in_ready !== 4'b0001) begin
      tests_failed++; $display("FAIL lock_next_ch0: got %b expected 0001", b1.in_ready);
    end
    @(negedge clk);
    tests_run++;
    if (out1() !== {1'b1, 1'b1, 2'd0, 8'hC0}) begin
      tests_failed++; $display("FAIL lock_out_ch0: got %h expected %h", out1(), {1'b1, 1'b1, 2'd0, 8'hC0});
    end
    b1.in_valid = 4'b0000;
  endtask

  // Pointer sits at 1 on entry, so ch0 winning over ch3 afterwards shows it was reset.
  task automatic test_reset_mid_packet();
    b1.in_valid = 4'b0010; b1.in_last = 4'b0000; b1.in_data[8 +: 8] = 8'hD1; #1;
    tests_run++;
    if (b1.in_ready !== 4'b0010) begin
      tests_failed++; $display("FAIL rmp_rdy: got %b expected 0010", b1.in_ready);
    end
    @(negedge clk);
    tests_run++;
    if (out1() !== {1'b1, 1'b0, 2'd1, 8'hD1}) begin
      tests_failed++; $display("FAIL rmp_beat1: got %h expected %h", out1(), {1'b1, 1'b0, 2'd1, 8'hD1});
    end
    rst1 = 1'b1; b1.in_data[8 +: 8] = 8'hD2; #1;
    tests_run++;
    if (b1.in_ready !== 4'b0000) begin
      tests_failed++; $display("FAIL rmp_rdy_rst: got %b expected 0000", b1.in_ready);
    end
    @(negedge clk);
    tests_run++;
    if (out1() !== 12'h000) begin
      tests_failed++; $display("FAIL rmp_flush: got %h expected 000", out1());
    end
    rst1 = 1'b0;
    b1.in_valid = 4'b1001; b1.in_last = 4'b1001;
    b1.in_data  = {8'hE3, 8'h00, 8'h00, 8'hE0}; #1;
    tests_run++;
    if (b1.in_ready !== 4'b0001) begin
      tests_failed++; $display("FAIL rmp_ptr0: got %b expected 0001", b1.in_ready);
    end
    @(negedge clk);
    tests_run++;
    if (out1() !== {1'b1, 1'b1, 2'd0, 8'hE0}) begin
      tests_failed++; $display("FAIL rmp_out_ch0: got %h expected %h", out1(), {1'b1, 1'b1, 2'd0, 8'hE0});
    end
    b1.in_valid = 4'b1000; #1;
    tests_run++;
    if (b1.in_ready !== 4'b1000) begin
      tests_failed++; $display("FAIL rmp_rdy_ch3: got %b expected 1000", b1.in_ready);
    end
    @(negedge clk);
    tests_run++;
    if (out1() !== {1'b1, 1'b1, 2'd3, 8'hE3}) begin
      tests_failed++; $display("FAIL rmp_out_ch3: got %h expected %h", out1(), {1'b1, 1'b1, 2'd3, 8'hE3});
    end
    b1.in_valid = 4'b0000;
  endtask

  task automatic test_wrap_n3();
    logic [11:0] exp;
    b2.in_valid = 3'b111; b2.in_last = 3'b111;
    b2.in_data  = {8'hF2, 8'hF1, 8'hF0};
    b2.out_ready = 1'b1;
    @(negedge clk);
    rst2 = 1'b0; #1;
    tests_run++;
    if (b2.in_ready !== 3'b001) begin
      tests_failed++; $display("FAIL n3_first: got %b expected 001", b2.in_ready);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      exp = {1'b1, 1'b1, 2'(k % 3), 8'(8'hF0 + k % 3)};
      tests_run++;
      if (out2() !== exp) begin
        tests_failed++; $display("FAIL n3_beat%0d: got %h expected %h", k, out2(), exp);
      end
    end
    b2.in_valid = 3'b000;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    b0.in_valid = '0; b0.in_data = '0; b0.in_last = '0; b0.out_ready = 1'b1;
    b1.in_valid = '0; b1.in_data = '0; b1.in_last = '0; b1.out_ready = 1'b1;
    b2.in_valid = '0; b2.in_data = '0; b2.in_last = '0; b2.out_ready = 1'b1;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_lock();
    test_reset_mid_packet();
    test_wrap_n3();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
